// File: rtl/perm_reader_if.sv
// rtl/perm_reader_if.sv - result-memory read port and permutation index stream for perm_reader
interface perm_reader_if #(
  parameter int M      = 13,
  parameter int SIGMA2 = 32
);
  logic              rd_en;
  logic [M-1:0]      rd_addr;
  logic [M-1:0]      index_out;
  logic [SIGMA2-1:0] rand_dout;
  logic              out_valid;
  logic              out_ready;
  logic [M-1:0]      out_index;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_valid, out_index, out_last,
    input  index_out, rand_dout, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_index, out_last,
    output index_out, rand_dout, out_ready
  );
endinterface

// File: rtl/perm_reader.sv
// rtl/perm_reader.sv - streams sorter result memory out as a permutation index stream
// Optional adjacent-key duplicate check enabled by macro PERM_READER_DUP_CHECK_EN.
module perm_reader #(
  parameter int M      = 13,
  parameter int SIGMA2 = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic dup_err,
  perm_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t       state, state_nxt;
  logic [M-1:0] cnt;
  logic [M-1:0] last_addr;
  logic         inflight;
  logic         inflight_last;
  logic [M-1:0] idx_mem [2];
  logic         lst_mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         pop;
  logic         issue;
  logic         cnt_max;
  logic [2:0]   occ;
  logic [2:0]   lim;

  assign pop     = (count != 2'd0) && bus.out_ready;
  assign cnt_max = (cnt == {M{1'b1}});
  // A pop this cycle frees a slot in time for the read's data, which keeps one element per cycle.
  assign occ     = {1'b0, count} + {2'b00, inflight};
  assign lim     = 3'd2 + {2'b00, pop};
  assign issue   = (state == RUN) && (occ < lim);

  assign bus.rd_en     = issue;
  assign bus.rd_addr   = issue ? cnt : last_addr;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_index = idx_mem[rd_ptr];
  assign bus.out_last  = lst_mem[rd_ptr] && (count != 2'd0);
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && cnt_max) state_nxt = DRAIN;
      DRAIN:   if (pop && lst_mem[rd_ptr]) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_addr     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      idx_mem[0]    <= '0;
      idx_mem[1]    <= '0;
      lst_mem[0]    <= 1'b0;
      lst_mem[1]    <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start)
        cnt <= '0;
      else if (issue && !cnt_max)
        cnt <= cnt + 1'b1;
      if (issue)
        last_addr <= cnt;
      inflight      <= issue;
      inflight_last <= issue && cnt_max;
      if (inflight) begin
        idx_mem[wr_ptr] <= bus.index_out;
        lst_mem[wr_ptr] <= inflight_last;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef PERM_READER_DUP_CHECK_EN
  logic [SIGMA2-1:0] prev_key;
  logic              have_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      dup_err   <= 1'b0;
      have_prev <= 1'b0;
      prev_key  <= '0;
    end else if (state == IDLE && start) begin
      dup_err   <= 1'b0;
      have_prev <= 1'b0;
    end else if (inflight) begin
      if (have_prev && bus.rand_dout == prev_key)
        dup_err <= 1'b1;
      prev_key  <= bus.rand_dout;
      have_prev <= 1'b1;
    end
  end
`else
  logic unused_keys;
  assign unused_keys = ^bus.rand_dout;
  assign dup_err     = 1'b0;
`endif

endmodule
